// File: rtl/seq_det_ctrl.sv
// Programmable serial sequence-detection controller.
// Matches a runtime-configured 1..PAT_W bit pattern on a gated serial
// stream, counts Mealy match pulses and raises irq at a programmed threshold.
module seq_det_ctrl #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_thresh,
    input  logic             start,
    input  logic             stop,
    input  logic             in_valid,
    input  logic             in,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             irq,
    output logic             busy,
    output logic             cfg_err,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
    logic [CNT_W-1:0]   thresh_q, thresh_d;
    logic [PAT_W-1:0]   history_q, history_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               irq_q, irq_d;
    logic               cfg_err_q, cfg_err_d;

    logic               accept;
    logic               len_legal;
    logic [PAT_W-1:0]   mask;
    logic [PAT_W-1:0]   window;
    logic [CNT_W-1:0]   cnt_inc;

    // Mealy match: the incoming bit completes the window formed by the history.
    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (LEN_W'(i) < len_q);
        end
        window    = {history_q[PAT_W-2:0], in};
        accept    = (state_q == ARMED) && in_valid;
        len_legal = (len_q != '0) && (len_q <= MAX_LEN);
        match     = accept && (fill_q >= (len_q - 1'b1)) &&
                    (((window ^ pattern_q) & mask) == '0);
        cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end

    // Next-state, configuration, history and counter update.
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        thresh_d  = thresh_q;
        history_d = history_q;
        fill_d    = fill_q;
        cnt_d     = cnt_q;
        irq_d     = irq_q;
        cfg_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_we) begin
                    pattern_d = cfg_pattern;
                    len_d     = cfg_len;
                    overlap_d = cfg_overlap;
                    thresh_d  = cfg_thresh;
                end
                if (start && !stop) begin
                    if (len_legal) begin
                        state_d   = ARMED;
                        history_d = '0;
                        fill_d    = '0;
                        cnt_d     = '0;
                        irq_d     = 1'b0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ARMED: begin
                if (accept) begin
                    if (match && !overlap_q) begin
                        history_d = '0;
                        fill_d    = '0;
                    end else begin
                        history_d = window;
                        fill_d    = (fill_q < MAX_LEN) ? fill_q + 1'b1 : fill_q;
                    end
                end
                if (match) begin
                    cnt_d = cnt_inc;
                    if ((thresh_q != '0) && (cnt_q + 1'b1 == thresh_q)) begin
                        irq_d   = 1'b1;
                        state_d = DONE;
                    end
                end
                if (stop) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (stop) begin
                    state_d = IDLE;
                    irq_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            thresh_q  <= '0;
            history_q <= '0;
            fill_q    <= '0;
            cnt_q     <= '0;
            irq_q     <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            thresh_q  <= thresh_d;
            history_q <= history_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
            irq_q     <= irq_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign match_cnt = cnt_q;
    assign irq       = irq_q;
    assign busy      = (state_q == ARMED);
    assign cfg_err   = cfg_err_q;
    assign state     = state_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed self-checking bench for seq_det_ctrl.
module tb_seq_det_ctrl;

    logic       clk;
    logic       rst;
    logic       cfg_we;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic [7:0] cfg_thresh;
    logic       start;
    logic       stop;
    logic       in_valid;
    logic       in_bit;
    logic       match;
    logic [7:0] match_cnt;
    logic       irq;
    logic       busy;
    logic       cfg_err;
    logic [1:0] state;

    int tests_run = 0;
    int tests_failed = 0;

    seq_det_ctrl #(.PAT_W(8), .LEN_W(4), .CNT_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .cfg_we(cfg_we),
        .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap),
        .cfg_thresh(cfg_thresh),
        .start(start),
        .stop(stop),
        .in_valid(in_valid),
        .in(in_bit),
        .match(match),
        .match_cnt(match_cnt),
        .irq(irq),
        .busy(busy),
        .cfg_err(cfg_err),
        .state(state)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence below never completes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present one serial bit; inputs change on the falling edge.
    task automatic applyStimulus(input logic b, input logic v, input logic exp_match,
                                 input string tag);
        @(negedge clk);
        in_bit   = b;
        in_valid = v;
        #1;
        checkOutput(tag, {31'd0, match}, {31'd0, exp_match});
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        @(negedge clk);
        in_valid = 1'b0;
        in_bit   = 1'b0;
    endtask

    task automatic configure(input logic [7:0] pat, input logic [3:0] len,
                             input logic ovl, input logic [7:0] thr);
        @(negedge clk);
        cfg_we      = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        cfg_thresh  = thr;
        @(negedge clk);
        cfg_we      = 1'b0;
    endtask

    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulseStop();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    // Stream 1101101101 with the expected match bit for each position.
    task automatic runStream(input logic [9:0] exp_m, input string tag);
        logic [9:0] bits;
        bits = 10'b1101101101;
        for (int i = 9; i >= 0; i--) begin
            applyStimulus(bits[i], 1'b1, exp_m[i], tag);
        end
        idleInputs();
    endtask

    initial begin
        rst         = 1'b0;
        cfg_we      = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        cfg_thresh  = '0;
        start       = 1'b0;
        stop        = 1'b0;
        in_valid    = 1'b0;
        in_bit      = 1'b0;

        // Reset state
        #12;
        rst = 1'b1;
        #1;
        checkOutput("reset_state", {30'd0, state}, 32'd0);
        checkOutput("reset_cnt", {24'd0, match_cnt}, 32'd0);
        checkOutput("reset_irq", {31'd0, irq}, 32'd0);
        checkOutput("reset_match", {31'd0, match}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);

        // Start with len=0 is rejected
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("cfg_err_pulse", {31'd0, cfg_err}, 32'd1);
        checkOutput("cfg_err_state", {30'd0, state}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("cfg_err_clear", {31'd0, cfg_err}, 32'd0);

        // Overlapping detection: matches on bits 4, 7, 10
        configure(8'h0D, 4'd4, 1'b1, 8'd0);
        pulseStart();
        checkOutput("ovl_armed", {30'd0, state}, 32'd1);
        checkOutput("ovl_busy", {31'd0, busy}, 32'd1);
        runStream(10'b0001001001, "ovl_match");
        checkOutput("ovl_cnt", {24'd0, match_cnt}, 32'd3);
        checkOutput("ovl_state", {30'd0, state}, 32'd1);
        pulseStop();
        checkOutput("ovl_stop_state", {30'd0, state}, 32'd0);

        // Non-overlapping detection: matches on bits 4 and 10
        configure(8'h0D, 4'd4, 1'b0, 8'd0);
        pulseStart();
        checkOutput("novl_cnt_clear", {24'd0, match_cnt}, 32'd0);
        runStream(10'b0001000001, "novl_match");
        checkOutput("novl_cnt", {24'd0, match_cnt}, 32'd2);
        pulseStop();

        // in_valid gap does not disturb the history
        configure(8'h0D, 4'd4, 1'b1, 8'd0);
        pulseStart();
        applyStimulus(1'b1, 1'b1, 1'b0, "gap_b1");
        applyStimulus(1'b1, 1'b1, 1'b0, "gap_b2");
        applyStimulus(1'b1, 1'b0, 1'b0, "gap_hole");
        applyStimulus(1'b0, 1'b1, 1'b0, "gap_b3");
        applyStimulus(1'b1, 1'b1, 1'b1, "gap_b4");
        idleInputs();
        checkOutput("gap_cnt", {24'd0, match_cnt}, 32'd1);
        pulseStop();

        // Threshold of 2 ends detection after bit 7
        configure(8'h0D, 4'd4, 1'b1, 8'd2);
        pulseStart();
        begin
            logic [9:0] bits;
            logic [9:0] exp_m;
            bits  = 10'b1101101101;
            exp_m = 10'b0001001000;
            for (int i = 9; i >= 0; i--) begin
                applyStimulus(bits[i], 1'b1, exp_m[i], "thr_match");
                if (i == 3) begin
                    checkOutput("thr_done_state", {30'd0, state}, 32'd2);
                    checkOutput("thr_irq", {31'd0, irq}, 32'd1);
                    checkOutput("thr_busy", {31'd0, busy}, 32'd0);
                end
            end
        end
        idleInputs();
        checkOutput("thr_cnt", {24'd0, match_cnt}, 32'd2);
        checkOutput("thr_irq_hold", {31'd0, irq}, 32'd1);
        pulseStop();
        checkOutput("thr_stop_state", {30'd0, state}, 32'd0);
        checkOutput("thr_stop_irq", {31'd0, irq}, 32'd0);

        // Config writes are ignored while armed
        configure(8'h0D, 4'd4, 1'b1, 8'd0);
        pulseStart();
        configure(8'hFF, 4'd8, 1'b0, 8'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, "lock_b1");
        applyStimulus(1'b1, 1'b1, 1'b0, "lock_b2");
        applyStimulus(1'b0, 1'b1, 1'b0, "lock_b3");
        applyStimulus(1'b1, 1'b1, 1'b1, "lock_b4");
        applyStimulus(1'b1, 1'b1, 1'b0, "lock_b5");
        checkOutput("lock_cnt", {24'd0, match_cnt}, 32'd1);
        checkOutput("lock_state", {30'd0, state}, 32'd1);

        // Asynchronous reset mid-stream
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_state", {30'd0, state}, 32'd0);
        checkOutput("async_cnt", {24'd0, match_cnt}, 32'd0);
        checkOutput("async_irq", {31'd0, irq}, 32'd0);
        checkOutput("async_match", {31'd0, match}, 32'd0);
        in_valid = 1'b0;
        #5;
        rst = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
